apb_mem_slave: RTL

- APB4 completer (responder) backed by a word-organised register-array memory.
- Sits on the PCLK side of the AHB-to-APB bridge as the default peripheral target and bench model.
- Supports programmable wait states, PSTRB byte-lane writes, and PSLVERR for out-of-range and protection violations.
- Single clock domain (PCLK).

---
 rtl/apb_mem_slave_if.sv | 41 ++++
 rtl/apb_mem_slave.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_if
//   APB4 bus bundle between a requester (master) and the apb_mem_slave
//   completer. PCLK/PRESETn are not part of the bundle; they are plain
//   ports on each module.
//
//   Signals (master -> slave):
//     PSEL     slave select
//     PENABLE  access phase indicator
//     PADDR    byte address [31:0]
//     PWRITE   1 = write, 0 = read
//     PWDATA   write data [31:0]
//     PSTRB    write byte strobes [3:0]
//     PPROT    protection [2:0]; bit 0 = privileged
//   Signals (slave -> master):
//     PRDATA   read data [31:0]
//     PREADY   transfer complete
//     PSLVERR  transfer error, valid with PREADY
// ---------------------------------------------------------------------------
interface apb_mem_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//   APB4 completer backed by a word-organised register-array memory.
//   Programmable access-phase wait states, PSTRB byte-lane writes, and
//   PSLVERR for out-of-window accesses and (optionally) unprivileged writes.
//   All outputs are registered. The memory array has no reset: contents
//   survive PRESETn.
//
//   Parameters:
//     P_ADDR_BASE   base byte address of the window (aligned to size)
//     P_SIZE_BYTES  window size in bytes, power of two, >= 4
//     P_WAIT        access-phase wait states before PREADY, 0..15
//     P_PRIV_WR     1 = reject writes with PPROT[0]=0 via PSLVERR
//
//   Ports:
//     PCLK     clock, rising edge
//     PRESETn  asynchronous active-low reset
//     apb      APB4 bus, slave modport
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter logic [31:0] P_ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned P_SIZE_BYTES = 1024,
    parameter int unsigned P_WAIT       = 0,
    parameter int unsigned P_PRIV_WR    = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_mem_slave_if.slave       apb
);

    localparam int unsigned LP_DEPTH    = P_SIZE_BYTES / 4;
    localparam int unsigned LP_ADDR_W   = $clog2(P_SIZE_BYTES);
    localparam int unsigned LP_IDX_W    = (LP_ADDR_W > 2) ? LP_ADDR_W - 2 : 1;
    localparam logic [31:0] LP_OFS_MASK = 32'(P_SIZE_BYTES - 1);
    localparam logic [3:0]  LP_WAIT     = 4'(P_WAIT);
    localparam logic        LP_PRIV_WR  = (P_PRIV_WR != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [LP_IDX_W-1:0]   r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [31:0]           r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;

    logic [31:0]           r_mem [LP_DEPTH];

    // -----------------------------------------------------------------------
    // Setup-phase decode
    // -----------------------------------------------------------------------
    logic                  w_setup;
    logic                  w_hit;
    logic                  w_setup_err;
    logic [LP_IDX_W-1:0]   w_setup_idx;
    logic                  w_unused_prot;

    assign w_setup     = apb.PSEL && !apb.PENABLE;
    assign w_hit       = (apb.PADDR & ~LP_OFS_MASK) == P_ADDR_BASE;
    assign w_setup_err = !w_hit || (apb.PWRITE && LP_PRIV_WR && !apb.PPROT[0]);
    // Offset within the window, byte bits dropped; PADDR[1:0] never matters.
    assign w_setup_idx = LP_IDX_W'((apb.PADDR & LP_OFS_MASK) >> 2);
    assign w_unused_prot = ^apb.PPROT[2:1];

    // -----------------------------------------------------------------------
    // Response source: with zero wait states the response is produced on the
    // same edge that accepts the setup phase, so the live decode has to be
    // used instead of the (not yet loaded) latched copy.
    // -----------------------------------------------------------------------
    logic [LP_IDX_W-1:0]   w_resp_idx;
    logic                  w_resp_write;
    logic                  w_resp_err;
    logic [31:0]           w_resp_rdata;

    always_comb begin
        w_resp_idx   = r_idx;
        w_resp_write = r_write;
        w_resp_err   = r_err;
        if (r_state == ST_IDLE) begin
            w_resp_idx   = w_setup_idx;
            w_resp_write = apb.PWRITE;
            w_resp_err   = w_setup_err;
        end
    end

    always_comb begin
        w_resp_rdata = '0;
        if (!w_resp_write && !w_resp_err) begin
            w_resp_rdata = r_mem[w_resp_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Transfer FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_prdata  <= '0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    // PENABLE high here is a protocol violation: ignored.
                    if (w_setup) begin
                        r_idx   <= w_setup_idx;
                        r_write <= apb.PWRITE;
                        r_err   <= w_setup_err;
                        r_cnt   <= LP_WAIT;
                        if (LP_WAIT != '0) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state   <= ST_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_resp_err;
                            r_prdata  <= w_resp_rdata;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!apb.PSEL) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (apb.PENABLE) begin
                        if (r_cnt <= 4'd1) begin
                            r_state   <= ST_RESP;
                            r_cnt     <= '0;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_resp_err;
                            r_prdata  <= w_resp_rdata;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end

                ST_RESP: begin
                    // One-cycle response; an abort lands here as well.
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_prdata  <= '0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_prdata  <= '0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Memory write: commits on the completing edge. PWDATA/PSTRB are taken
    // live at that edge. An asynchronous reset forces ST_IDLE, so a pending
    // write cannot commit.
    // -----------------------------------------------------------------------
    logic w_commit;

    assign w_commit = (r_state == ST_RESP) && apb.PSEL && apb.PENABLE &&
                      r_write && !r_err;

    always_ff @(posedge PCLK) begin
        if (w_commit) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (apb.PSTRB[n]) begin
                    r_mem[r_idx][8*n +: 8] <= apb.PWDATA[8*n +: 8];
                end
            end
        end
    end

    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = r_pready;
    assign apb.PSLVERR = r_pslverr;

endmodule
